sdram_wr_burst_gen: RTL and testbench

- Write-side front end that sits directly upstream of the SDRAM write FSM.
- Buffers a 16-bit user write stream in an internal synchronous FIFO.
- Once a full burst is buffered, it issues a write request: wr_en with the current 24-bit address and burst length.
- Supplies data words in step with wr_ack, then advances the address on wr_end, wrapping inside a configurable region.

---
 rtl/sdram_wr_burst_gen_pkg.sv | 37 +++
 rtl/sdram_sync_fifo.sv | 65 ++++++
 rtl/sdram_wr_burst_gen.sv | 151 +++++++++++++++
 tb/tb_sdram_wr_burst_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wr_burst_gen_pkg.sv
// Shared SDRAM controller widths, address field layout and burst address helper.
package sdram_wr_burst_gen_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 24;
   localparam int unsigned BST_W  = 10;

   localparam int unsigned BANK_W = 2;   // addr[23:22]
   localparam int unsigned ROW_W  = 13;  // addr[21:9]
   localparam int unsigned COL_W  = 9;   // addr[8:0]

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
   } sdram_addr_t;

   // Next burst start: advance by len, or wrap to min if the next burst would pass max.
   function automatic logic [ADDR_W-1:0] next_burst_addr(
      input logic [ADDR_W-1:0] cur,
      input logic [ADDR_W-1:0] min,
      input logic [ADDR_W-1:0] max,
      input logic [BST_W-1:0]  len
   );
      logic [ADDR_W:0] nxt;
      logic [ADDR_W:0] last;
      logic [ADDR_W:0] len_ext;
      len_ext = {{(ADDR_W + 1 - BST_W){1'b0}}, len};
      nxt     = {1'b0, cur} + len_ext;
      last    = nxt + len_ext - (ADDR_W + 1)'(1);
      if (last > {1'b0, max}) begin
         return min;
      end
      return nxt[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO with registered read data (one cycle after pop) and occupancy count.
module sdram_sync_fifo
   import sdram_wr_burst_gen_pkg::*;
#(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned AW    = 9,
   parameter int unsigned DW    = DATA_W
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_push_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_pop_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [DW-1:0] r_pop_data;
   logic          w_push;
   logic          w_pop;

   assign o_full     = (r_count == (AW + 1)'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_pop_data;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Storage is not reset; the pointers alone define valid contents.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pop_data <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_pop_data <= r_mem[r_rd_ptr];
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_wr_burst_gen.sv
// Buffers the user write stream and issues address/length burst requests to the SDRAM write FSM.
module sdram_wr_burst_gen
   import sdram_wr_burst_gen_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 512,
   parameter int unsigned FIFO_AW    = 9
) (
   input  logic              wr_clk,
   input  logic              wr_rst_n,
   input  logic              init_end,
   input  logic              usr_wr_vld,
   input  logic [DATA_W-1:0] usr_wr_data,
   output logic              usr_wr_rdy,
   input  logic [ADDR_W-1:0] cfg_addr_min,
   input  logic [ADDR_W-1:0] cfg_addr_max,
   input  logic [BST_W-1:0]  cfg_bst_len,
   input  logic              cfg_load,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [BST_W-1:0]  wr_bst_len,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ack,
   input  logic              wr_end,
   output logic [FIFO_AW:0]  fifo_cnt,
   output logic              err_udf
);

   typedef enum logic [1:0] {StIdle, StReq, StXfer, StWaitEnd} state_e;

   localparam logic [BST_W-1:0] BstOne = BST_W'(1);

   state_e            r_state, w_state_d;
   logic [ADDR_W-1:0] r_addr, w_addr_d;
   logic [BST_W-1:0]  r_len, w_len_d;
   logic [BST_W-1:0]  r_ack_cnt, w_ack_cnt_d;
   logic              r_wr_en, w_wr_en_d;
   logic              r_load_pend, w_load_pend_d;
   logic              r_err_udf;

   logic              w_full;
   logic              w_empty;
   logic [FIFO_AW:0]  w_fifo_cnt;
   logic [BST_W-1:0]  w_bst_eff;
   logic              w_ack_live;
   logic              w_pop;

   assign w_bst_eff  = (cfg_bst_len == '0) ? BstOne : cfg_bst_len;
   // Acks once the burst count is reached are not data strobes for this burst.
   assign w_ack_live = wr_ack && (r_state != StWaitEnd);
   assign w_pop      = w_ack_live && !w_empty;

   sdram_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW),
      .DW    (DATA_W)
   ) u_fifo (
      .i_clk       (wr_clk),
      .i_rst_n     (wr_rst_n),
      .i_push      (usr_wr_vld),
      .i_push_data (usr_wr_data),
      .i_pop       (w_pop),
      .o_pop_data  (wr_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_fifo_cnt)
   );

   always_comb begin
      w_state_d     = r_state;
      w_addr_d      = r_addr;
      w_len_d       = r_len;
      w_ack_cnt_d   = r_ack_cnt;
      w_wr_en_d     = r_wr_en;
      w_load_pend_d = r_load_pend;
      unique case (r_state)
         StIdle: begin
            if (cfg_load || r_load_pend) begin
               w_addr_d      = cfg_addr_min;
               w_load_pend_d = 1'b0;
            end else if (init_end && (32'(w_fifo_cnt) >= 32'(w_bst_eff))) begin
               w_len_d   = w_bst_eff;
               w_wr_en_d = 1'b1;
               w_state_d = StReq;
            end
         end
         StReq: begin
            if (cfg_load) begin
               w_load_pend_d = 1'b1;
            end
            if (wr_ack) begin
               w_wr_en_d   = 1'b0;
               w_ack_cnt_d = BstOne;
               w_state_d   = (r_len == BstOne) ? StWaitEnd : StXfer;
            end
         end
         StXfer: begin
            if (cfg_load) begin
               w_load_pend_d = 1'b1;
            end
            if (wr_ack) begin
               w_ack_cnt_d = r_ack_cnt + 1'b1;
               if (w_ack_cnt_d == r_len) begin
                  w_state_d = StWaitEnd;
               end
            end
         end
         StWaitEnd: begin
            if (wr_end) begin
               if (cfg_load || r_load_pend) begin
                  w_addr_d = cfg_addr_min;
               end else begin
                  w_addr_d = next_burst_addr(r_addr, cfg_addr_min, cfg_addr_max, r_len);
               end
               w_load_pend_d = 1'b0;
               w_state_d     = StIdle;
            end else if (cfg_load) begin
               w_load_pend_d = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (!wr_rst_n) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_len       <= '0;
         r_ack_cnt   <= '0;
         r_wr_en     <= 1'b0;
         r_load_pend <= 1'b0;
         r_err_udf   <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_addr      <= w_addr_d;
         r_len       <= w_len_d;
         r_ack_cnt   <= w_ack_cnt_d;
         r_wr_en     <= w_wr_en_d;
         r_load_pend <= w_load_pend_d;
         r_err_udf   <= r_err_udf | (w_ack_live && w_empty);
      end
   end

   assign usr_wr_rdy = !w_full;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_addr;
   assign wr_bst_len = r_len;
   assign fifo_cnt   = w_fifo_cnt;
   assign err_udf    = r_err_udf;

endmodule

// File: tb/tb_sdram_wr_burst_gen.sv
// Directed bench: scoreboard of pushed words checked against wr_data as bursts are acknowledged.
module tb_sdram_wr_burst_gen;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic        wr_clk = 1'b0;
   logic        wr_rst_n;
   logic        init_end;
   logic        usr_wr_vld;
   logic [15:0] usr_wr_data;
   logic        usr_wr_rdy;
   logic [23:0] cfg_addr_min;
   logic [23:0] cfg_addr_max;
   logic [9:0]  cfg_bst_len;
   logic        cfg_load;
   logic        wr_en;
   logic [23:0] wr_addr;
   logic [9:0]  wr_bst_len;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic        wr_end;
   logic [AW:0] fifo_cnt;
   logic        err_udf;

   int          n_checks = 0;
   int          n_err    = 0;
   int          model_cnt = 0;
   logic [15:0] sb_q [$];
   logic [15:0] last_pop = 16'h0;
   logic [15:0] cc_data  = 16'h5000;

   always #5 wr_clk = ~wr_clk;

   sdram_wr_burst_gen #(
      .FIFO_DEPTH (DEPTH),
      .FIFO_AW    (AW)
   ) dut (
      .wr_clk       (wr_clk),
      .wr_rst_n     (wr_rst_n),
      .init_end     (init_end),
      .usr_wr_vld   (usr_wr_vld),
      .usr_wr_data  (usr_wr_data),
      .usr_wr_rdy   (usr_wr_rdy),
      .cfg_addr_min (cfg_addr_min),
      .cfg_addr_max (cfg_addr_max),
      .cfg_bst_len  (cfg_bst_len),
      .cfg_load     (cfg_load),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_bst_len   (wr_bst_len),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .wr_end       (wr_end),
      .fifo_cnt     (fifo_cnt),
      .err_udf      (err_udf)
   );

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] d);
      logic exp_rdy;
      exp_rdy = (model_cnt < int'(DEPTH));
      chk("usr_wr_rdy", 32'(usr_wr_rdy), 32'(exp_rdy));
      usr_wr_vld  = 1'b1;
      usr_wr_data = d;
      tick();
      usr_wr_vld = 1'b0;
      if (exp_rdy) begin
         sb_q.push_back(d);
         model_cnt++;
      end
   endtask

   task automatic wait_wr_en(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (wr_en === 1'b1) break;
         tick();
      end
      chk("wr_en_req", 32'(wr_en), 32'd1);
   endtask

   // One ack cycle; optionally pushes a fresh word in the same cycle.
   task automatic ack_one(input bit cc);
      logic exp_rdy;
      logic do_pop;
      exp_rdy = (model_cnt < int'(DEPTH));
      do_pop  = (model_cnt > 0);
      wr_ack  = 1'b1;
      if (cc) begin
         chk("cc_rdy", 32'(usr_wr_rdy), 32'(exp_rdy));
         usr_wr_vld  = 1'b1;
         usr_wr_data = cc_data;
      end
      tick();
      wr_ack     = 1'b0;
      usr_wr_vld = 1'b0;
      if (do_pop) begin
         last_pop = sb_q.pop_front();
         model_cnt--;
         chk("wr_data", 32'(wr_data), 32'(last_pop));
      end else begin
         chk("sb_underrun", 32'(model_cnt), 32'd1);
      end
      if (cc && exp_rdy) begin
         sb_q.push_back(cc_data);
         model_cnt++;
         cc_data = cc_data + 16'h1;
      end
   endtask

   task automatic run_burst(input logic [23:0] exp_addr, input int len, input bit cc,
                            input int load_at);
      wait_wr_en(64);
      chk("req_addr", 32'(wr_addr), 32'(exp_addr));
      chk("req_len", 32'(wr_bst_len), 32'(len));
      for (int i = 0; i < len; i++) begin
         cfg_load = (i == load_at);
         ack_one(cc);
         cfg_load = 1'b0;
         if (i == 0) chk("wr_en_drop", 32'(wr_en), 32'd0);
         if (cc) chk("cnt_track", 32'(fifo_cnt), 32'(model_cnt));
      end
      tick();
      chk("data_hold", 32'(wr_data), 32'(last_pop));
      chk("no_reissue", 32'(wr_en), 32'd0);
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
   endtask

   initial begin
      wr_rst_n = 1'b0; init_end = 1'b0; usr_wr_vld = 1'b0; usr_wr_data = '0;
      cfg_addr_min = '0; cfg_addr_max = '0; cfg_bst_len = '0; cfg_load = 1'b0;
      wr_ack = 1'b0; wr_end = 1'b0;
      tick(); tick();
      wr_rst_n = 1'b1;
      tick();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_len", 32'(wr_bst_len), 32'd0);
      chk("rst_data", 32'(wr_data), 32'd0);
      chk("rst_cnt", 32'(fifo_cnt), 32'd0);
      chk("rst_err", 32'(err_udf), 32'd0);
      chk("rst_rdy", 32'(usr_wr_rdy), 32'd1);

      // Basic burst plus threshold
      cfg_addr_min = 24'h000100; cfg_addr_max = 24'h0001FF; cfg_bst_len = 10'd8;
      init_end = 1'b1; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      chk("load_addr", 32'(wr_addr), 32'h100);
      for (int i = 0; i < 7; i++) push_word(16'h1000 + 16'(i));
      tick(); tick();
      chk("thresh_7", 32'(wr_en), 32'd0);
      chk("cnt_7", 32'(fifo_cnt), 32'd7);
      push_word(16'h1007);
      chk("thresh_8_same", 32'(wr_en), 32'd0);
      tick();
      chk("thresh_8_next", 32'(wr_en), 32'd1);
      run_burst(24'h000100, 8, 1'b0, -1);
      chk("addr_after_1", 32'(wr_addr), 32'h108);
      chk("cnt_after_1", 32'(fifo_cnt), 32'd0);

      // init_end gating
      init_end = 1'b0;
      for (int i = 0; i < 8; i++) push_word(16'h2000 + 16'(i));
      for (int i = 0; i < 4; i++) tick();
      chk("gate_init", 32'(wr_en), 32'd0);
      init_end = 1'b1;
      run_burst(24'h000108, 8, 1'b0, -1);
      chk("addr_after_2", 32'(wr_addr), 32'h110);

      // Wrap inside region
      cfg_addr_max = 24'h00010F; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 8; i++) push_word(16'h2100 + 16'(b * 16 + i));
         run_burst((b == 1) ? 24'h000108 : 24'h000100, 8, 1'b0, -1);
      end
      chk("wrap_addr", 32'(wr_addr), 32'h108);

      // Backpressure: 20 offered, 16 accepted
      init_end = 1'b0;
      for (int i = 0; i < 20; i++) push_word(16'h3000 + 16'(i));
      chk("full_rdy", 32'(usr_wr_rdy), 32'd0);
      chk("full_cnt", 32'(fifo_cnt), 32'd16);
      init_end = 1'b1;
      run_burst(24'h000108, 8, 1'b0, -1);
      run_burst(24'h000100, 8, 1'b0, -1);
      chk("bp_drain", 32'(fifo_cnt), 32'd0);

      // Concurrent push/pop, bst=4
      cfg_bst_len = 10'd4;
      for (int i = 0; i < 4; i++) push_word(16'h4000 + 16'(i));
      run_burst(24'h000108, 4, 1'b1, -1);
      chk("cc_cnt", 32'(fifo_cnt), 32'd4);
      run_burst(24'h00010C, 4, 1'b0, -1);
      chk("cc_wrap_addr", 32'(wr_addr), 32'h100);
      chk("cc_drain", 32'(fifo_cnt), 32'd0);

      // cfg_load during XFER
      cfg_addr_min = 24'h000400; cfg_addr_max = 24'h0004FF;
      for (int i = 0; i < 4; i++) push_word(16'h6000 + 16'(i));
      run_burst(24'h000100, 4, 1'b0, 2);
      chk("pend_load_addr", 32'(wr_addr), 32'h400);
      for (int i = 0; i < 4; i++) push_word(16'h6100 + 16'(i));
      run_burst(24'h000400, 4, 1'b0, -1);
      chk("post_load_addr", 32'(wr_addr), 32'h404);

      // Reset mid-XFER
      for (int i = 0; i < 4; i++) push_word(16'h7000 + 16'(i));
      wait_wr_en(64);
      ack_one(1'b0);
      ack_one(1'b0);
      wr_rst_n = 1'b0;
      tick();
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
      chk("mid_rst_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_data", 32'(wr_data), 32'd0);
      wr_rst_n = 1'b1;
      sb_q.delete();
      model_cnt = 0;
      tick();

      // Underflow error
      chk("err_pre", 32'(err_udf), 32'd0);
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      chk("err_set", 32'(err_udf), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("err_sticky", 32'(err_udf), 32'd1);
      chk("err_cnt", 32'(fifo_cnt), 32'd0);
      chk("err_no_req", 32'(wr_en), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
